// File: rtl/ysyx_25020037_axi_arbiter_if.sv
// AXI4 bundle (AR, R, AW, W, B) used on every arbiter port.
// Ports (modports):
//   master : drives AR/AW/W requests, R/B readies; receives readies and responses.
//   slave  : receives requests; drives AR/AW/W readies and R/B responses.
interface ysyx_25020037_axi_arbiter_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ID_W   = 4;
   localparam int unsigned LEN_W  = 8;
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              arvalid;
   logic [ADDR_W-1:0] araddr;
   logic [ID_W-1:0]   arid;
   logic [LEN_W-1:0]  arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arready;

   logic              rvalid;
   logic [1:0]        rresp;
   logic [DATA_W-1:0] rdata;
   logic              rlast;
   logic [ID_W-1:0]   rid;
   logic              rready;

   logic              awvalid;
   logic [ADDR_W-1:0] awaddr;
   logic [ID_W-1:0]   awid;
   logic [LEN_W-1:0]  awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              awready;

   logic              wvalid;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wlast;
   logic              wready;

   logic              bvalid;
   logic [1:0]        bresp;
   logic [ID_W-1:0]   bid;
   logic              bready;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst,
      input  arready,
      input  rvalid, rresp, rdata, rlast, rid,
      output rready,
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bresp, bid,
      output bready
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst,
      output arready,
      output rvalid, rresp, rdata, rlast, rid,
      input  rready,
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bresp, bid,
      input  bready
   );
endinterface

// File: rtl/ysyx_25020037_axi_arbiter.sv
// Two-master / one-slave AXI4 arbiter: IFU (m0, read only) and LSU (m1, read
// and write) share one memory port. One whole transaction is granted at a time
// and the grant is held until its last response handshake.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   m0        : IFU side (slave modport; AW/W/B unused and tied off)
//   m1        : LSU side (slave modport)
//   s         : crossbar side (master modport)
//   arb_grant : owner, 00 none / 01 IFU read / 10 LSU read / 11 LSU write
// Optional feature: define YSYX_25020037_ARB_RR_EN for round-robin between the
// two read masters; otherwise the LSU read always beats the IFU read.
module ysyx_25020037_axi_arbiter (
   input  logic                               clk,
   input  logic                               rst,
   ysyx_25020037_axi_arbiter_if.slave         m0,
   ysyx_25020037_axi_arbiter_if.slave         m1,
   ysyx_25020037_axi_arbiter_if.master        s,
   output logic [1:0]                         arb_grant
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RD_M0 = 2'b01,
      RD_M1 = 2'b10,
      WR_M1 = 2'b11
   } state_t;

   state_t state;
   logic   rd_pick_m1;

`ifdef YSYX_25020037_ARB_RR_EN
   // Last read owner: 0 IFU, 1 LSU.
   logic   last_rd;

   // On contention the master that did not read last wins.
   assign rd_pick_m1 = m1.arvalid && (!m0.arvalid || !last_rd);
`else
   assign rd_pick_m1 = m1.arvalid;
`endif

   // Grant FSM: arbitrate in IDLE, hold until the final R beat or the B response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
`ifdef YSYX_25020037_ARB_RR_EN
         last_rd <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (m1.awvalid) begin
                  state <= WR_M1;
               end else if (rd_pick_m1) begin
                  state <= RD_M1;
`ifdef YSYX_25020037_ARB_RR_EN
                  last_rd <= 1'b1;
`endif
               end else if (m0.arvalid) begin
                  state <= RD_M0;
`ifdef YSYX_25020037_ARB_RR_EN
                  last_rd <= 1'b0;
`endif
               end
            end
            RD_M0, RD_M1: begin
               if (s.rvalid && s.rready && s.rlast) state <= IDLE;
            end
            WR_M1: begin
               if (s.bvalid && s.bready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign arb_grant = state;

   // Channel mux: everything is zero unless the state connects it.
   always_comb begin
      s.arvalid  = 1'b0;
      s.araddr   = '0;
      s.arid     = '0;
      s.arlen    = '0;
      s.arsize   = '0;
      s.arburst  = '0;
      s.rready   = 1'b0;
      s.awvalid  = 1'b0;
      s.awaddr   = '0;
      s.awid     = '0;
      s.awlen    = '0;
      s.awsize   = '0;
      s.awburst  = '0;
      s.wvalid   = 1'b0;
      s.wdata    = '0;
      s.wstrb    = '0;
      s.wlast    = 1'b0;
      s.bready   = 1'b0;

      m0.arready = 1'b0;
      m0.rvalid  = 1'b0;
      m0.rresp   = '0;
      m0.rdata   = '0;
      m0.rlast   = 1'b0;
      m0.rid     = '0;
      m0.awready = 1'b0;
      m0.wready  = 1'b0;
      m0.bvalid  = 1'b0;
      m0.bresp   = '0;
      m0.bid     = '0;

      m1.arready = 1'b0;
      m1.rvalid  = 1'b0;
      m1.rresp   = '0;
      m1.rdata   = '0;
      m1.rlast   = 1'b0;
      m1.rid     = '0;
      m1.awready = 1'b0;
      m1.wready  = 1'b0;
      m1.bvalid  = 1'b0;
      m1.bresp   = '0;
      m1.bid     = '0;

      case (state)
         RD_M0: begin
            s.arvalid  = m0.arvalid;
            s.araddr   = m0.araddr;
            s.arid     = m0.arid;
            s.arlen    = m0.arlen;
            s.arsize   = m0.arsize;
            s.arburst  = m0.arburst;
            m0.arready = s.arready;
            m0.rvalid  = s.rvalid;
            m0.rresp   = s.rresp;
            m0.rdata   = s.rdata;
            m0.rlast   = s.rlast;
            m0.rid     = s.rid;
            s.rready   = m0.rready;
         end
         RD_M1: begin
            s.arvalid  = m1.arvalid;
            s.araddr   = m1.araddr;
            s.arid     = m1.arid;
            s.arlen    = m1.arlen;
            s.arsize   = m1.arsize;
            s.arburst  = m1.arburst;
            m1.arready = s.arready;
            m1.rvalid  = s.rvalid;
            m1.rresp   = s.rresp;
            m1.rdata   = s.rdata;
            m1.rlast   = s.rlast;
            m1.rid     = s.rid;
            s.rready   = m1.rready;
         end
         WR_M1: begin
            s.awvalid  = m1.awvalid;
            s.awaddr   = m1.awaddr;
            s.awid     = m1.awid;
            s.awlen    = m1.awlen;
            s.awsize   = m1.awsize;
            s.awburst  = m1.awburst;
            m1.awready = s.awready;
            s.wvalid   = m1.wvalid;
            s.wdata    = m1.wdata;
            s.wstrb    = m1.wstrb;
            s.wlast    = m1.wlast;
            m1.wready  = s.wready;
            m1.bvalid  = s.bvalid;
            m1.bresp   = s.bresp;
            m1.bid     = s.bid;
            s.bready   = m1.bready;
         end
         default: ;
      endcase
   end

   // The IFU never writes; its write-side inputs are intentionally ignored.
   logic unused_m0_wr;
   assign unused_m0_wr = ^{m0.awvalid, m0.awaddr, m0.awid, m0.awlen, m0.awsize,
                           m0.awburst, m0.wvalid, m0.wdata, m0.wstrb, m0.wlast,
                           m0.bready};

endmodule

// File: tb/tb_ysyx_25020037_axi_arbiter.sv
// Self-checking bench for ysyx_25020037_axi_arbiter: a behavioural AXI slave,
// per-master response scoreboards, a table of single-master reads and
// hand-written contention / write / burst / reset sequences.
module tb_ysyx_25020037_axi_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] arb_grant;

   ysyx_25020037_axi_arbiter_if m0 ();
   ysyx_25020037_axi_arbiter_if m1 ();
   ysyx_25020037_axi_arbiter_if s  ();

   ysyx_25020037_axi_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .m0        (m0),
      .m1        (m1),
      .s         (s),
      .arb_grant (arb_grant)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } beat_t;

   typedef struct {
      logic [1:0] resp;
      logic [3:0] id;
   } bexp_t;

   typedef struct {
      bit          mst;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [3:0]  id;
      logic [1:0]  exp_grant;
   } vec_t;

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned cyc = 0;

   beat_t       q_m0[$];
   beat_t       q_m1[$];
   bexp_t       q_b[$];
   logic [1:0]  grant_log[$];
   int unsigned grant_cyc_log[$];
   logic [1:0]  prev_grant = 2'b00;
   int unsigned m0_last_cyc = 0;

   logic [1:0]  slv_bresp = 2'b00;
   logic [31:0] exp_awaddr = '0;
   logic [31:0] exp_wdata = '0;
   logic [3:0]  exp_wstrb = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
   endtask

   // Slave read data / response derived from the address.
   function automatic logic [31:0] rdata_of(input logic [31:0] a, input int b);
      if (a == 32'h3000_0000) return 32'hDEAD_BEEF;
      return (a + 32'(b) * 32'd4) ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [1:0] rresp_of(input logic [31:0] a);
      return a[5:4];
   endfunction

   // Behavioural slave: sample handshakes at negedge, update outputs after posedge.
   initial begin : slave_model
      logic        ar_hs, r_hs, aw_hs, w_hs, b_hs, rst_s, rl;
      logic        busy, aw_got, w_got;
      logic [31:0] a;
      logic [7:0]  l;
      logic [3:0]  rid_l, bid_l;
      int          beat;
      busy = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      a = '0; l = '0; rid_l = '0; bid_l = '0; beat = 0;
      s.arready = 1'b1; s.rvalid = 1'b0; s.rresp = '0; s.rdata = '0; s.rlast = 1'b0; s.rid = '0;
      s.awready = 1'b1; s.wready = 1'b1; s.bvalid = 1'b0; s.bresp = '0; s.bid = '0;
      forever begin
         @(negedge clk);
         rst_s = rst;
         ar_hs = s.arvalid && s.arready;
         r_hs  = s.rvalid && s.rready;
         rl    = s.rlast;
         aw_hs = s.awvalid && s.awready;
         w_hs  = s.wvalid && s.wready;
         b_hs  = s.bvalid && s.bready;
         if (ar_hs) begin a = s.araddr; l = s.arlen; rid_l = s.arid; end
         if (aw_hs) bid_l = s.awid;
         @(posedge clk);
         #1;
         if (rst_s) begin
            busy = 1'b0; aw_got = 1'b0; w_got = 1'b0;
            s.rvalid = 1'b0; s.rlast = 1'b0; s.bvalid = 1'b0;
         end else begin
            if (r_hs) begin
               if (rl) begin
                  busy = 1'b0;
                  s.rvalid = 1'b0;
               end else begin
                  beat++;
                  s.rdata = rdata_of(a, beat);
                  s.rlast = (beat == int'(l));
               end
            end
            if (ar_hs) begin
               busy = 1'b1;
               beat = 0;
               s.rvalid = 1'b1;
               s.rdata  = rdata_of(a, 0);
               s.rresp  = rresp_of(a);
               s.rlast  = (l == 8'd0);
               s.rid    = rid_l;
            end
            if (b_hs) s.bvalid = 1'b0;
            if (aw_hs) aw_got = 1'b1;
            if (w_hs) w_got = 1'b1;
            if (aw_got && w_got) begin
               s.bvalid = 1'b1;
               s.bresp  = slv_bresp;
               s.bid    = bid_l;
               aw_got   = 1'b0;
               w_got    = 1'b0;
            end
         end
         s.arready = !busy;
         s.awready = !aw_got && !s.bvalid;
         s.wready  = !w_got && !s.bvalid;
      end
   end

   // Monitor: scoreboard pops, payload checks, routing invariants, grant log.
   always @(negedge clk) begin
      if (!rst) begin
         logic [4:0] viol;
         beat_t      e;
         bexp_t      be;
         if (m0.rvalid && m0.rready) begin
            chk("m0_r_grant", 32'(arb_grant), 32'h1);
            if (m0.rlast) m0_last_cyc = cyc;
            if (q_m0.size() == 0) begin
               chk("m0_r_unexpected", 32'(m0.rvalid), 32'h0);
            end else begin
               e = q_m0.pop_front();
               chk("m0_rdata", m0.rdata, e.data);
               chk("m0_rresp", 32'(m0.rresp), 32'(e.resp));
               chk("m0_rlast", 32'(m0.rlast), 32'(e.last));
               chk("m0_rid", 32'(m0.rid), 32'(e.id));
            end
         end
         if (m1.rvalid && m1.rready) begin
            chk("m1_r_grant", 32'(arb_grant), 32'h2);
            if (q_m1.size() == 0) begin
               chk("m1_r_unexpected", 32'(m1.rvalid), 32'h0);
            end else begin
               e = q_m1.pop_front();
               chk("m1_rdata", m1.rdata, e.data);
               chk("m1_rresp", 32'(m1.rresp), 32'(e.resp));
               chk("m1_rlast", 32'(m1.rlast), 32'(e.last));
               chk("m1_rid", 32'(m1.rid), 32'(e.id));
            end
         end
         if (m1.bvalid && m1.bready) begin
            chk("m1_b_grant", 32'(arb_grant), 32'h3);
            if (q_b.size() == 0) begin
               chk("m1_b_unexpected", 32'(m1.bvalid), 32'h0);
            end else begin
               be = q_b.pop_front();
               chk("m1_bresp", 32'(m1.bresp), 32'(be.resp));
               chk("m1_bid", 32'(m1.bid), 32'(be.id));
            end
         end
         if (s.awvalid && s.awready) begin
            chk("s_awaddr", s.awaddr, exp_awaddr);
            chk("s_awlen_size_burst", 32'({s.awlen, s.awsize, s.awburst}), 32'({8'd0, 3'd2, 2'b01}));
         end
         if (s.wvalid && s.wready) begin
            chk("s_wdata", s.wdata, exp_wdata);
            chk("s_wstrb_wlast", 32'({s.wstrb, s.wlast}), 32'({exp_wstrb, 1'b1}));
         end
         viol    = '0;
         viol[0] = (arb_grant != 2'b01) && (m0.arready || m0.rvalid);
         viol[1] = (arb_grant != 2'b10) && (m1.arready || m1.rvalid);
         viol[2] = (arb_grant != 2'b11) && (m1.awready || m1.wready || m1.bvalid);
         viol[3] = m0.awready || m0.wready || m0.bvalid || (|m0.bresp) || (|m0.bid);
         viol[4] = (arb_grant == 2'b00) && (s.arvalid || s.awvalid || s.wvalid || s.rready ||
                   s.bready || (|s.araddr) || (|s.awaddr) || (|s.wdata));
         chk("routing_invariants", 32'(viol), 32'h0);
         if (arb_grant != prev_grant && arb_grant != 2'b00) begin
            grant_log.push_back(arb_grant);
            grant_cyc_log.push_back(cyc);
         end
      end
      prev_grant = arb_grant;
   end

   // Issue one read on master mst; expected beats go to that master's scoreboard.
   task automatic rd_req(input bit mst, input logic [31:0] addr, input logic [7:0] len,
                         input logic [3:0] id);
      int t;
      for (int b = 0; b <= int'(len); b++) begin
         beat_t e;
         e.data = rdata_of(addr, b);
         e.resp = rresp_of(addr);
         e.last = (b == int'(len));
         e.id   = id;
         if (mst) q_m1.push_back(e);
         else     q_m0.push_back(e);
      end
      if (mst) begin
         m1.arvalid = 1'b1; m1.araddr = addr; m1.arlen = len; m1.arid = id;
         m1.arsize = 3'd2; m1.arburst = 2'b01;
      end else begin
         m0.arvalid = 1'b1; m0.araddr = addr; m0.arlen = len; m0.arid = id;
         m0.arsize = 3'd2; m0.arburst = 2'b01;
      end
      t = 0;
      forever begin
         @(negedge clk);
         if (mst ? (m1.arvalid && m1.arready) : (m0.arvalid && m0.arready)) break;
         t++;
         if (t > 300) begin
            fail_timeout(mst ? "m1_ar_accept" : "m0_ar_accept");
            break;
         end
      end
      @(posedge clk);
      #1;
      if (mst) m1.arvalid = 1'b0;
      else     m0.arvalid = 1'b0;
   endtask

   // Single-beat LSU write; the slave answers with bresp.
   task automatic wr_req(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input logic [3:0] id, input logic [1:0] bresp);
      bexp_t e;
      e.resp = bresp;
      e.id   = id;
      q_b.push_back(e);
      exp_awaddr = addr; exp_wdata = data; exp_wstrb = strb; slv_bresp = bresp;
      m1.awvalid = 1'b1; m1.awaddr = addr; m1.awid = id; m1.awlen = 8'd0;
      m1.awsize = 3'd2; m1.awburst = 2'b01;
      m1.wvalid = 1'b1; m1.wdata = data; m1.wstrb = strb; m1.wlast = 1'b1;
      fork
         begin
            int t = 0;
            forever begin
               @(negedge clk);
               if (m1.awvalid && m1.awready) break;
               t++;
               if (t > 300) begin fail_timeout("m1_aw_accept"); break; end
            end
            @(posedge clk); #1;
            m1.awvalid = 1'b0;
         end
         begin
            int t = 0;
            forever begin
               @(negedge clk);
               if (m1.wvalid && m1.wready) break;
               t++;
               if (t > 300) begin fail_timeout("m1_w_accept"); break; end
            end
            @(posedge clk); #1;
            m1.wvalid = 1'b0;
         end
      join
   endtask

   task automatic wait_idle(input int lim);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(arb_grant == 2'b00 && q_m0.size() == 0 && q_m1.size() == 0 &&
                   q_b.size() == 0) && t < lim);
      if (t >= lim) fail_timeout("wait_idle");
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : main
      vec_t       vt[5];
      logic [1:0] exp_seq[3];
      int         t;

      vt[0] = '{1'b0, 32'h3000_0000, 8'd0, 4'h1, 2'b01};
      vt[1] = '{1'b1, 32'h8000_0010, 8'd0, 4'h2, 2'b10};
      vt[2] = '{1'b0, 32'h1000_0030, 8'd1, 4'h3, 2'b01};
      vt[3] = '{1'b1, 32'h2000_0020, 8'd2, 4'h4, 2'b10};
      vt[4] = '{1'b0, 32'hFFFF_FFFC, 8'd0, 4'hF, 2'b01};

      m0.arvalid = 1'b0; m0.araddr = '0; m0.arid = '0; m0.arlen = '0; m0.arsize = '0; m0.arburst = '0;
      m0.rready = 1'b1;
      m0.awvalid = 1'b0; m0.awaddr = '0; m0.awid = '0; m0.awlen = '0; m0.awsize = '0; m0.awburst = '0;
      m0.wvalid = 1'b0; m0.wdata = '0; m0.wstrb = '0; m0.wlast = 1'b0; m0.bready = 1'b0;
      m1.arvalid = 1'b0; m1.araddr = '0; m1.arid = '0; m1.arlen = '0; m1.arsize = '0; m1.arburst = '0;
      m1.rready = 1'b1;
      m1.awvalid = 1'b0; m1.awaddr = '0; m1.awid = '0; m1.awlen = '0; m1.awsize = '0; m1.awburst = '0;
      m1.wvalid = 1'b0; m1.wdata = '0; m1.wstrb = '0; m1.wlast = 1'b0; m1.bready = 1'b1;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Idle after reset.
      repeat (5) begin
         @(negedge clk);
         chk("idle_grant", 32'(arb_grant), 32'h0);
         chk("idle_s_valids", 32'({s.arvalid, s.awvalid, s.wvalid}), 32'h0);
         chk("idle_arready", 32'({m0.arready, m1.arready}), 32'h0);
      end

      // Single-master reads from the table.
      foreach (vt[i]) begin
         @(posedge clk);
         #1;
         fork
            rd_req(vt[i].mst, vt[i].addr, vt[i].len, vt[i].id);
            begin
               @(negedge clk);
               chk("pre_grant", 32'(arb_grant), 32'h0);
               @(posedge clk);
               #2;
               chk("grant", 32'(arb_grant), 32'(vt[i].exp_grant));
               chk("s_arvalid", 32'(s.arvalid), 32'h1);
               chk("s_araddr", s.araddr, vt[i].addr);
               chk("s_arlen", 32'(s.arlen), 32'(vt[i].len));
               chk("s_arid", 32'(s.arid), 32'(vt[i].id));
               chk("s_arsize_burst", 32'({s.arsize, s.arburst}), 32'({3'd2, 2'b01}));
            end
         join
         wait_idle(100);
         chk("grant_after", 32'(arb_grant), 32'h0);
      end

      // Two contended rounds: IFU holds one request, LSU issues two back to back.
`ifdef YSYX_25020037_ARB_RR_EN
      exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10;
`else
      exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01;
`endif
      grant_log.delete();
      grant_cyc_log.delete();
      @(posedge clk);
      #1;
      fork
         rd_req(1'b0, 32'h4000_0000, 8'd0, 4'h5);
         begin
            rd_req(1'b1, 32'h5000_0000, 8'd0, 4'h6);
            rd_req(1'b1, 32'h5000_0100, 8'd0, 4'h7);
         end
      join
      wait_idle(100);
      chk("contend_grants", 32'(grant_log.size()), 32'd3);
      for (int k = 0; k < 3; k++) begin
         if (k < grant_log.size()) chk("contend_order", 32'(grant_log[k]), 32'(exp_seq[k]));
      end

      // LSU write with error response while the IFU read waits.
      grant_log.delete();
      grant_cyc_log.delete();
      @(posedge clk);
      #1;
      fork
         wr_req(32'hA000_0004, 32'h1122_3344, 4'hF, 4'h9, 2'b10);
         rd_req(1'b0, 32'h3000_0000, 8'd0, 4'h8);
         begin
            @(posedge clk);
            #2;
            chk("wr_grant", 32'(arb_grant), 32'h3);
            chk("wr_s_awvalid_wvalid", 32'({s.awvalid, s.wvalid}), 32'h3);
            chk("wr_s_awaddr", s.awaddr, 32'hA000_0004);
            chk("wr_s_wdata", s.wdata, 32'h1122_3344);
            chk("wr_m0_arready", 32'(m0.arready), 32'h0);
            chk("wr_s_arvalid", 32'(s.arvalid), 32'h0);
         end
      join
      wait_idle(100);
      chk("wr_then_rd_grants", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         chk("wr_first", 32'(grant_log[0]), 32'h3);
         chk("rd_after_wr", 32'(grant_log[1]), 32'h1);
      end

      // IFU 4-beat burst; LSU read queued behind it.
      grant_log.delete();
      grant_cyc_log.delete();
      @(posedge clk);
      #1;
      fork
         rd_req(1'b0, 32'hA000_0000, 8'd3, 4'h1);
         begin
            @(posedge clk);
            #1;
            rd_req(1'b1, 32'h6000_0000, 8'd0, 4'h2);
         end
      join
      wait_idle(200);
      chk("burst_grants", 32'(grant_log.size()), 32'd2);
      if (grant_log.size() == 2) begin
         chk("burst_owner", 32'(grant_log[0]), 32'h1);
         chk("burst_next_owner", 32'(grant_log[1]), 32'h2);
         chk("burst_next_latency", grant_cyc_log[1], m0_last_cyc + 32'd2);
      end

      // Reset in the middle of an LSU burst.
      @(posedge clk);
      #1;
      rd_req(1'b1, 32'h7000_0000, 8'd7, 4'h3);
      t = 0;
      while (q_m1.size() > 6 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) fail_timeout("midburst_beats");
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #2;
      chk("rst_grant", 32'(arb_grant), 32'h0);
      chk("rst_handshakes", 32'({s.arvalid, s.rready, m1.rvalid, m1.arready, m1.rlast, m0.rvalid}), 32'h0);
      chk("rst_m1_rdata", m1.rdata, 32'h0);
      chk("rst_s_araddr", s.araddr, 32'h0);
      rst = 1'b0;
      q_m0.delete();
      q_m1.delete();
      q_b.delete();

      // Recovery read after the abort.
      @(posedge clk);
      #1;
      rd_req(1'b0, 32'h3000_0000, 8'd0, 4'hA);
      wait_idle(100);
      chk("final_grant", 32'(arb_grant), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
